// File: rtl/reg_file.sv
// reg_file: x1-x31 integer register file with write-back bypass and a per-register
// in-flight write scoreboard that raises the decode RAW/full stall.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        ws_rd,
  input  logic              ws_reg_wen,
  input  logic [DATA_W-1:0] ws_reg_wdata,
  input  logic [4:0]        ds_rs1,
  input  logic [4:0]        ds_rs2,
  input  logic              ds_rs1_used,
  input  logic              ds_rs2_used,
  input  logic              ds_issue_valid,
  input  logic              ds_issue_wen,
  input  logic [4:0]        ds_issue_rd,
  input  logic              kill_valid,
  input  logic [4:0]        kill_rd,
  output logic [DATA_W-1:0] ds_rdata1,
  output logic [DATA_W-1:0] ds_rdata2,
  output logic              ds_stall
);
  logic [DATA_W-1:0] data [32];
  logic [PEND_W-1:0] eff [32];
  logic              accept;
  assign data[0] = '0;
  assign eff[0]  = '0;
  for (genvar i = 1; i < 32; i++) begin : g_r
    logic [DATA_W-1:0] q;
    logic [PEND_W-1:0] c;
    logic [PEND_W:0]   d, n;
    logic              wr;
    assign wr = ws_reg_wen && ws_rd == 5'(i);
    assign d = (PEND_W+1)'(wr) + (PEND_W+1)'(kill_valid && kill_rd == 5'(i));
    assign n = {1'b0, c} + (PEND_W+1)'(accept && ds_issue_rd == 5'(i));
    // retires and kills this cycle already count as gone, so a same-cycle retire releases the stall
    assign eff[i] = {1'b0, c} >= d ? PEND_W'({1'b0, c} - d) : '0;
    assign data[i] = q;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        q <= '0;
        c <= '0;
      end else begin
        if (wr) q <= ws_reg_wdata;
        c <= n >= d ? PEND_W'(n - d) : '0;
        assert (n >= d) else $error("reg_file: pending count underflow on x%0d", i);
      end
  end
  assign ds_stall = (ds_rs1_used && eff[ds_rs1] != '0) ||
                    (ds_rs2_used && eff[ds_rs2] != '0) ||
                    (ds_issue_valid && ds_issue_wen && eff[ds_issue_rd] == '1);
  assign accept = ds_issue_valid && ds_issue_wen && !ds_stall;
  assign ds_rdata1 = ds_rs1 == 5'd0 ? '0 : (ws_reg_wen && ws_rd == ds_rs1) ? ws_reg_wdata : data[ds_rs1];
  assign ds_rdata2 = ds_rs2 == 5'd0 ? '0 : (ws_reg_wen && ws_rd == ds_rs2) ? ws_reg_wdata : data[ds_rs2];
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed vectors for reg_file; expectations are queued by the driver, checked by a monitor.
module tb_reg_file;
  logic        clk = 0, rst = 1;
  logic [4:0]  ws_rd, ds_rs1, ds_rs2, ds_issue_rd, kill_rd;
  logic        ws_reg_wen, ds_rs1_used, ds_rs2_used, ds_issue_valid, ds_issue_wen, kill_valid;
  logic [31:0] ws_reg_wdata, ds_rdata1, ds_rdata2;
  logic        ds_stall;
  logic        vld = 0;
  int          total = 0, bad = 0;
  typedef struct { string n; logic [31:0] r1, r2; logic st; } exp_t;
  exp_t sb [$];

  reg_file dut (
    .clk(clk), .rst(rst), .ws_rd(ws_rd), .ws_reg_wen(ws_reg_wen), .ws_reg_wdata(ws_reg_wdata),
    .ds_rs1(ds_rs1), .ds_rs2(ds_rs2), .ds_rs1_used(ds_rs1_used), .ds_rs2_used(ds_rs2_used),
    .ds_issue_valid(ds_issue_valid), .ds_issue_wen(ds_issue_wen), .ds_issue_rd(ds_issue_rd),
    .kill_valid(kill_valid), .kill_rd(kill_rd),
    .ds_rdata1(ds_rdata1), .ds_rdata2(ds_rdata2), .ds_stall(ds_stall)
  );

  always #5 clk = ~clk;

  task automatic clr();
    ws_rd = 0; ws_reg_wen = 0; ws_reg_wdata = 0;
    ds_rs1 = 0; ds_rs2 = 0; ds_rs1_used = 0; ds_rs2_used = 0;
    ds_issue_valid = 0; ds_issue_wen = 0; ds_issue_rd = 0;
    kill_valid = 0; kill_rd = 0;
  endtask

  task automatic chk(string n, logic [31:0] e1, logic [31:0] e2, logic est);
    sb.push_back('{n, e1, e2, est});
    vld = 1;
    @(posedge clk); #1;
    vld = 0;
  endtask

  task automatic iss(logic [4:0] rd);
    ds_issue_valid = 1; ds_issue_wen = 1; ds_issue_rd = rd;
  endtask

  task automatic wb(logic [4:0] rd, logic [31:0] d);
    ws_reg_wen = 1; ws_rd = rd; ws_reg_wdata = d;
  endtask

  always @(negedge clk) if (vld) begin
    exp_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL sb_empty: no expectation queued for presented output");
    end else begin
      e = sb.pop_front();
      total++;
      if (ds_rdata1 !== e.r1) begin bad++; $display("FAIL %s rdata1: got %h want %h", e.n, ds_rdata1, e.r1); end
      total++;
      if (ds_rdata2 !== e.r2) begin bad++; $display("FAIL %s rdata2: got %h want %h", e.n, ds_rdata2, e.r2); end
      total++;
      if (ds_stall !== e.st) begin bad++; $display("FAIL %s stall: got %b want %b", e.n, ds_stall, e.st); end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: run did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int i = 1; i < 32; i++) begin
      clr(); ds_rs1 = 5'(i); ds_rs2 = 5'(32 - i); ds_rs1_used = 1; ds_rs2_used = 1;
      chk("reset_read", 0, 0, 0);
    end
    clr(); iss(5);                                   chk("iss5", 0, 0, 0);
    clr(); ds_rs1 = 5; ds_rs1_used = 1;              chk("stall5", 0, 0, 1);
    wb(5, 32'hDEADBEEF);                             chk("bypass5", 32'hDEADBEEF, 0, 0);
    clr(); ds_rs1 = 5; ds_rs1_used = 1;              chk("stored5", 32'hDEADBEEF, 0, 0);
    ds_rs2 = 5; ds_rs2_used = 1;                     chk("stored5b", 32'hDEADBEEF, 32'hDEADBEEF, 0);
    clr(); wb(0, 32'h1234); ds_rs1_used = 1;         chk("x0_write", 0, 0, 0);
    clr(); ds_rs1_used = 1; ds_rs2_used = 1;         chk("x0_read", 0, 0, 0);
    clr(); iss(7); ds_rs2 = 5; ds_rs2_used = 1;      chk("iss7", 0, 32'hDEADBEEF, 0);
    clr(); ds_rs2 = 7; ds_rs2_used = 1;              chk("raw7_a", 0, 0, 1);
                                                     chk("raw7_b", 0, 0, 1);
    wb(7, 32'hCAFEF00D);                             chk("raw7_rel", 0, 32'hCAFEF00D, 0);
    clr(); iss(3);                                   chk("iss3_1", 0, 0, 0);
                                                     chk("iss3_2", 0, 0, 0);
                                                     chk("iss3_3", 0, 0, 0);
                                                     chk("iss3_full", 0, 0, 1);
                                                     chk("iss3_hold", 0, 0, 1);
    wb(3, 32'h31);                                   chk("iss3_retire", 0, 0, 0);
    clr(); iss(3);                                   chk("iss3_still3", 0, 0, 1);
    clr(); ds_rs1 = 3; ds_rs1_used = 1; wb(3, 32'h32); chk("drain3_1", 32'h32, 0, 1);
    wb(3, 32'h33);                                   chk("drain3_2", 32'h33, 0, 1);
    wb(3, 32'h34);                                   chk("drain3_3", 32'h34, 0, 0);
    clr(); iss(9);                                   chk("iss9_1", 0, 0, 0);
                                                     chk("iss9_2", 0, 0, 0);
    clr(); ds_rs1 = 9; ds_rs1_used = 1;              chk("stall9", 0, 0, 1);
    wb(9, 32'h99); kill_valid = 1; kill_rd = 9;      chk("kill_wb9", 32'h99, 0, 0);
    clr(); ds_rs1 = 9; ds_rs1_used = 1;              chk("after9", 32'h99, 0, 0);
    clr(); iss(4);                                   chk("iss4_1", 0, 0, 0);
                                                     chk("iss4_2", 0, 0, 0);
    wb(4, 32'h55);                                   chk("wb_iss4", 0, 0, 0);
    clr(); ds_rs1 = 4; ds_rs2 = 4; ds_rs1_used = 1; ds_rs2_used = 1;
                                                     chk("pend4", 32'h55, 32'h55, 1);
    rst = 1;                                         chk("arst", 0, 0, 0);
    rst = 0;                                         chk("post_rst", 0, 0, 0);
    clr();
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_drain: left %0d want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_file.md
# reg_file

Integer register file plus write-pending scoreboard for the 5-stage RISC-V core; it is the receiving end of the write-back stage's register write port. It holds x0–x31, serves the two decode-stage source reads combinationally with same-cycle write-back bypass, and tracks in-flight writes per register. From that it raises a decode stall for RAW hazards.

## Interface
Parameters:
- DATA_W, 32, register width
- PEND_W, 2, width of per-register in-flight write counter (max 2^PEND_W−1 outstanding writes per register)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- ws_rd  in  5  write-back destination register
- ws_reg_wen  in  1  write-back write enable
- ws_reg_wdata  in  DATA_W  write-back data
- ds_rs1, ds_rs2  in  5  decode-stage source register indices
- ds_rs1_used, ds_rs2_used  in  1  source actually read by the decoded instruction
- ds_issue_valid  in  1  decoded instruction wants to leave decode
- ds_issue_wen  in  1  that instruction will write a register
- ds_issue_rd  in  5  its destination
- kill_valid  in  1  an issued, not-yet-retired writing instruction was squashed
- kill_rd  in  5  destination of the squashed instruction
- ds_rdata1, ds_rdata2  out  DATA_W  source operand values
- ds_stall  out  1  decode must hold

## Operation
- Storage: 31 × DATA_W registers for x1–x31; x0 is not stored. Reads of x0 return 0. Writes, issues and kills to x0 are ignored.
- Write: on a rising edge with ws_reg_wen=1 and ws_rd≠0, reg[ws_rd] ← ws_reg_wdata.
- Read: ds_rdataN = 0 if ds_rsN=0.
  - Otherwise, if ws_reg_wen and ws_rd=ds_rsN, the output is ws_reg_wdata (bypass).
  - Otherwise the output is reg[ds_rsN].
- Scoreboard: one PEND_W-bit counter cnt[r] per r in 1..31.
  - inc[r] = issue accepted (ds_issue_valid & ~ds_stall & ds_issue_wen & ds_issue_rd=r).
  - dec[r] = (ws_reg_wen & ws_rd=r) + (kill_valid & kill_rd=r).
  - Next-cycle cnt[r] = cnt[r] + inc[r] − dec[r]. Simultaneous inc and one dec leaves cnt unchanged. When ws_rd=kill_rd, both decrements apply.
  - A decrement below 0 is a protocol error. The counter saturates at 0 and a simulation-only assertion fires.
- Effective pending count: eff[r] = cnt[r] − dec[r], evaluated combinationally.
- ds_stall = 1 when any of the following holds:
  - ds_rs1_used and ds_rs1≠0 and eff[ds_rs1]>0
  - ds_rs2_used and ds_rs2≠0 and eff[ds_rs2]>0
  - ds_issue_valid and ds_issue_wen and ds_issue_rd≠0 and eff[ds_issue_rd] = 2^PEND_W−1 (counter full)
- ds_stall does not depend on ds_issue_valid for the source checks. An issue presented while ds_stall=1 is not accepted and causes no counter change.

## Timing
- Reset (rst=1, asynchronous):
  - All registers are 0 and all counters are 0.
  - ds_rdata1/2 = 0 unless a bypass is active.
  - ds_stall = 0 unless ws/kill inputs are already driving counters, which cannot happen since all are 0.
- Reset released mid-operation discards all pending state. Upstream flushes the pipe on the same reset.
- Read latency is 0 cycles (combinational). Write-to-read through storage takes 1 edge. Write-to-read through the bypass takes 0 cycles.
- Retire and stall: a write-back in cycle N releases a dependent stall in the same cycle N, via eff.
- Issue and stall: an issue accepted at edge N makes a dependent instruction in decode at cycle N+1 stall.
- Combinational paths: ws_* → ds_rdata*, ds_stall; ds_rs* → ds_rdata*, ds_stall; kill_* → ds_stall. There are no paths from outputs back to inputs inside the block.

## Test plan
- Reset then read: assert rst, release, read x1..x31 → all ds_rdata = 0, ds_stall = 0.
- Write/bypass: write x5=0xDEADBEEF with ds_rs1=5 in the same cycle → ds_rdata1=0xDEADBEEF that cycle and every following cycle. Write x0=0x1234 → x0 still reads 0.
- RAW stall: issue rd=7 with wen, next cycle decode ds_rs2=7 used → ds_stall=1. Hold until ws_rd=7 with ws_reg_wen=1 → ds_stall=0 in that same cycle and ds_rdata2 = ws_reg_wdata.
- Multiple in-flight writes: issue rd=3 three times (cnt=3). A fourth issue of rd=3 → ds_stall=1 and cnt stays 3. Retire one → the fourth issue is accepted the same cycle and cnt remains 3.
- Kill and retire collision: cnt[9]=2, then in one cycle ws_rd=9 with wen and kill_rd=9 → cnt[9]=0 next cycle, and a source read of x9 no longer stalls.
- Async reset mid-operation: cnt[4]=2 with x4=0x55, assert rst between edges → x4 reads 0 and ds_stall deasserts immediately, without waiting for a clock edge.
